// File: rtl/mem_load_sequencer.sv
// Copies blocks from main memory into IM (or DM) under control of a command ROM.
// Define DM_LOAD_EN to enable DM destination copies; otherwise DM commands abort the run.
module mem_load_sequencer #(
  parameter logic [9:0] IM_START = 10'h07F,
  parameter int         ROM_AW   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [35:0]       rom_ir,
  output logic              mem_enable,
  output logic              mem_en_read,
  output logic [13:0]       mem_addr,
  input  logic [31:0]       mem_data,
  output logic              im_enable,
  output logic              im_en_write,
  output logic [9:0]        im_addr,
  output logic              dm_enable,
  output logic              dm_en_write,
  output logic [13:0]       dm_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              ir_enable,
  output logic [15:0]       total_ir,
  output logic              load_im_done,
  output logic              eop,
  output logic              err
);

`ifdef DM_LOAD_EN
  localparam bit DM_EN = 1'b1;
`else
  localparam bit DM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, COPY, DRAIN, DONE} state_t;

  state_t            state;
  logic [ROM_AW-1:0] index;
  logic [10:0]       im_cnt;     // extra MSB flags a target past the top of IM
  logic [13:0]       dm_cnt;
  logic [15:0]       reads_left;
  logic [15:0]       cmd_count;
  logic              cmd_en;
  logic              cmd_sel;
  logic              im_wr;
  logic              dm_wr;

  logic [15:0] dec_count;
  logic        dec_term;
  logic        dec_skip;
  logic [10:0] im_target;
  logic        do_advance;

  assign dec_count  = {5'b0, rom_ir[15:5]};
  assign dec_term   = (rom_ir == 36'h0);
  assign dec_skip   = !rom_ir[34] || !rom_ir[32] || (dec_count == 16'h0);
  // Address the next read's write will land on, after any write in flight retires.
  assign im_target  = im_cnt + {10'b0, im_wr};
  assign do_advance = (state == DRAIN) || (state == DECODE && !dec_term && dec_skip);

  // NOTE: every register below is updated with <= so all state changes land together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      index        <= '0;
      im_cnt       <= {1'b0, IM_START};
      dm_cnt       <= '0;
      reads_left   <= '0;
      cmd_count    <= '0;
      cmd_en       <= 1'b0;
      cmd_sel      <= 1'b0;
      rom_addr     <= '0;
      mem_enable   <= 1'b0;
      mem_en_read  <= 1'b0;
      mem_addr     <= '0;
      im_wr        <= 1'b0;
      dm_wr        <= 1'b0;
      busy         <= 1'b0;
      load_im_done <= 1'b0;
      eop          <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (im_wr) im_cnt <= im_cnt + 11'd1;
      if (dm_wr) dm_cnt <= dm_cnt + 14'd1;
      im_wr <= 1'b0;
      dm_wr <= 1'b0;

      case (state)
        IDLE: if (start) begin
          state        <= FETCH;
          busy         <= 1'b1;
          load_im_done <= 1'b0;
          eop          <= 1'b0;
          err          <= 1'b0;
          index        <= '0;
          rom_addr     <= '0;
          im_cnt       <= {1'b0, IM_START};
          dm_cnt       <= '0;
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (dec_term) begin
            eop   <= 1'b1;
            state <= DONE;
          end else if (!dec_skip) begin
            if (rom_ir[33] && !DM_EN) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              if (rom_ir[35]) begin
                if (rom_ir[33]) dm_cnt <= '0;
                else            im_cnt <= {1'b0, IM_START};
              end
              mem_addr    <= rom_ir[29:16];
              mem_enable  <= 1'b1;
              mem_en_read <= 1'b1;
              reads_left  <= dec_count;
              cmd_count   <= dec_count;
              cmd_en      <= rom_ir[34];
              cmd_sel     <= rom_ir[33];
              state       <= COPY;
            end
          end
        end
        COPY: begin
          if (!cmd_sel && im_target[10]) begin
            mem_enable  <= 1'b0;
            mem_en_read <= 1'b0;
            err         <= 1'b1;
            state       <= DONE;
          end else begin
            if (cmd_sel) dm_wr <= 1'b1;
            else         im_wr <= 1'b1;
            mem_addr   <= mem_addr + 14'd1;
            reads_left <= reads_left - 16'd1;
            if (reads_left == 16'd1) begin
              mem_enable  <= 1'b0;
              mem_en_read <= 1'b0;
              state       <= DRAIN;
            end
          end
        end
        DRAIN: ;
        DONE: begin
          busy         <= 1'b0;
          load_im_done <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (do_advance) begin
        if (index == {ROM_AW{1'b1}}) begin
          err   <= 1'b1;
          state <= DONE;
        end else begin
          index    <= index + {{(ROM_AW-1){1'b0}}, 1'b1};
          rom_addr <= index + {{(ROM_AW-1){1'b0}}, 1'b1};
          state    <= FETCH;
        end
      end
    end
  end

  // NOTE: both outputs get a default first so no path through the case leaves a latch.
  always_comb begin
    total_ir  = 16'h0;
    ir_enable = 1'b0;
    case (state)
      DECODE: begin
        total_ir  = dec_count;
        ir_enable = rom_ir[34];
      end
      COPY, DRAIN: begin
        total_ir  = cmd_count;
        ir_enable = cmd_en;
      end
      default: ;
    endcase
  end

  assign im_enable   = im_wr;
  assign im_en_write = im_wr;
  assign im_addr     = im_cnt[9:0];
  assign wr_data     = (im_wr || dm_wr) ? mem_data : 32'h0;

`ifdef DM_LOAD_EN
  assign dm_enable   = dm_wr;
  assign dm_en_write = dm_wr;
  assign dm_addr     = dm_cnt;
`else
  assign dm_enable   = 1'b0;
  assign dm_en_write = 1'b0;
  assign dm_addr     = 14'h0;
`endif

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Bench for mem_load_sequencer: ROM/memory models, table of load runs, write scoreboard,
// plus a hand-written reset-during-copy sequence.
module tb_mem_load_sequencer;
  localparam logic [9:0] IM_START = 10'h07F;
`ifdef DM_LOAD_EN
  localparam bit DM_EN = 1'b1;
`else
  localparam bit DM_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [35:0] rom_ir = 36'h0;
  logic        mem_enable, mem_en_read;
  logic [13:0] mem_addr;
  logic [31:0] mem_data = 32'h0;
  logic        im_enable, im_en_write;
  logic [9:0]  im_addr;
  logic        dm_enable, dm_en_write;
  logic [13:0] dm_addr;
  logic [31:0] wr_data;
  logic        busy, ir_enable;
  logic [15:0] total_ir;
  logic        load_im_done, eop, err;

  mem_load_sequencer #(.IM_START(IM_START), .ROM_AW(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_ir(rom_ir),
    .mem_enable(mem_enable), .mem_en_read(mem_en_read), .mem_addr(mem_addr), .mem_data(mem_data),
    .im_enable(im_enable), .im_en_write(im_en_write), .im_addr(im_addr),
    .dm_enable(dm_enable), .dm_en_write(dm_en_write), .dm_addr(dm_addr),
    .wr_data(wr_data), .busy(busy), .ir_enable(ir_enable), .total_ir(total_ir),
    .load_im_done(load_im_done), .eop(eop), .err(err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {4'hA, a, 4'h5, ~a[9:0]};
  endfunction

  logic [35:0] rom_mem [256];
  always @(posedge clock) rom_ir <= rom_mem[rom_addr];
  always @(posedge clock) if (mem_enable && mem_en_read) mem_data <= mem_word(mem_addr);

  typedef struct packed {
    logic        is_dm;
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int n_reads, n_writes, first_read, last_write;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic write_seen(input logic is_dm, input logic [13:0] addr, input logic [1:0] strobes);
    wr_t e;
    n_writes++;
    last_write = cycle;
    check(is_dm ? "dm strobe pair" : "im strobe pair", 64'(strobes), 64'(2'b11));
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected write: got dm=%0d addr %0h data %0h, want none", is_dm, addr, wr_data);
    end else begin
      e = sb.pop_front();
      check("write dm/addr/data", 64'({is_dm, addr, wr_data}), 64'(e));
    end
  endtask

  always @(negedge clock) begin
    cycle++;
    if (mem_enable || mem_en_read) begin
      n_reads++;
      if (first_read < 0) first_read = cycle;
      check("read strobe pair", 64'({mem_enable, mem_en_read}), 64'(2'b11));
    end
    if (im_enable || im_en_write) write_seen(1'b0, {4'b0, im_addr}, {im_enable, im_en_write});
    if (dm_enable || dm_en_write) write_seen(1'b1, dm_addr, {dm_enable, dm_en_write});
  end

  // Transaction-level model of a whole run: walks the ROM and queues the expected writes.
  task automatic build_expect();
    int idx, im, dm, src, cnt;
    bit stop;
    logic [35:0] w;
    idx = 0; im = int'(IM_START); dm = 0; stop = 1'b0;
    while (!stop) begin
      w = rom_mem[idx];
      if (w == 36'h0) stop = 1'b1;
      else begin
        cnt = int'(w[15:0]) / 32;
        if (w[34] && w[32] && cnt > 0) begin
          if (w[33] && !DM_EN) stop = 1'b1;
          else begin
            if (w[35]) begin
              if (w[33]) dm = 0; else im = int'(IM_START);
            end
            src = int'(w[29:16]);
            for (int k = 0; k < cnt && !stop; k++) begin
              if (w[33]) begin
                sb.push_back({1'b1, 14'(dm), mem_word(14'(src))});
                dm = (dm + 1) % 16384;
              end else if (im > 1023) stop = 1'b1;
              else begin
                sb.push_back({1'b0, 14'(im), mem_word(14'(src))});
                im++;
              end
              src = (src + 1) % 16384;
            end
          end
        end
        if (!stop) begin
          if (idx == 255) stop = 1'b1; else idx++;
        end
      end
    end
  endtask

  typedef struct {
    string           name;
    logic [5:0][35:0] rom;
    logic [35:0]     fill;
    bit              exp_eop;
    bit              exp_err;
    int              exp_reads;
    int              exp_writes;
    int              exp_span;
    int              restart_at;
  } case_t;

  function automatic case_t mk(input string name, input logic [35:0] w0, w1, w2, w3, w4, w5,
                               input logic [35:0] fill, input bit e_eop, e_err,
                               input int reads, writes, span, restart);
    case_t c;
    c.name = name; c.fill = fill;
    c.rom[0] = w0; c.rom[1] = w1; c.rom[2] = w2; c.rom[3] = w3; c.rom[4] = w4; c.rom[5] = w5;
    c.exp_eop = e_eop; c.exp_err = e_err;
    c.exp_reads = reads; c.exp_writes = writes; c.exp_span = span; c.restart_at = restart;
    return c;
  endfunction

  case_t cases[8];

  task automatic run_case(input int i);
    int c;
    for (int j = 0; j < 256; j++) rom_mem[j] = cases[i].fill;
    for (int j = 0; j < 6; j++) rom_mem[j] = cases[i].rom[j];
    sb.delete();
    build_expect();
    n_reads = 0; n_writes = 0; first_read = -1; last_write = -1;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    check({cases[i].name, " busy after start"}, 64'(busy), 64'(1));
    check({cases[i].name, " done cleared"}, 64'(load_im_done), 64'(0));
    if (cases[i].restart_at > 0) begin
      repeat (cases[i].restart_at) @(negedge clock);
      start = 1'b1;
      @(negedge clock) start = 1'b0;
    end
    c = 0;
    while (!load_im_done && c < 5000) begin
      @(negedge clock);
      c++;
    end
    check({cases[i].name, " load_im_done"}, 64'(load_im_done), 64'(1));
    check({cases[i].name, " busy idle"}, 64'(busy), 64'(0));
    check({cases[i].name, " eop"}, 64'(eop), 64'(cases[i].exp_eop));
    check({cases[i].name, " err"}, 64'(err), 64'(cases[i].exp_err));
    check({cases[i].name, " reads"}, 64'(n_reads), 64'(cases[i].exp_reads));
    check({cases[i].name, " writes"}, 64'(n_writes), 64'(cases[i].exp_writes));
    check({cases[i].name, " pending writes"}, 64'(sb.size()), 64'(0));
    if (cases[i].exp_span >= 0)
      check({cases[i].name, " read-to-last-write span"}, 64'(last_write - first_read), 64'(cases[i].exp_span));
  endtask

  initial begin
    int c;
    cases[0] = mk("im2", 36'hD_0010_0040, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0, 1, 0, 2, 2, 2, 0);
    cases[1] = mk("noop", 36'h1_0005_0080, 36'hD_0020_001F, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0,
                  1, 0, 0, 0, -1, 0);
    cases[2] = mk("persist", 36'h4_0100_0040, 36'h5_0100_0060, 36'h5_0200_0020, 36'hD_0300_0040,
                  36'h0, 36'h0, 36'h0, 1, 0, 6, 6, -1, 0);
`ifdef DM_LOAD_EN
    cases[3] = mk("dm_wrap", 36'hF_3FFF_0060, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0, 1, 0, 3, 3, 3, 0);
`else
    cases[3] = mk("dm_off", 36'hF_3FFF_0060, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0, 0, 1, 0, 0, -1, 0);
`endif
    cases[4] = mk("src_hi_bits", 36'h5_FFFE_0040, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0,
                  1, 0, 2, 2, 2, 0);
    cases[5] = mk("index_wrap", 36'h1_0000_0020, 36'h1_0000_0020, 36'h1_0000_0020, 36'h1_0000_0020,
                  36'h1_0000_0020, 36'h1_0000_0020, 36'h1_0000_0020, 0, 1, 0, 0, -1, 0);
    cases[6] = mk("im_overflow", 36'hD_0000_4000, 36'h5_1000_4000, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0,
                  0, 1, 898, 897, -1, 0);
    cases[7] = mk("restart_ignored", 36'hD_0040_0080, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0, 36'h0,
                  1, 0, 4, 4, 4, 3);
    for (int j = 0; j < 256; j++) rom_mem[j] = 36'h0;

    repeat (3) @(negedge clock);
    check("reset busy", 64'(busy), 64'(0));
    check("reset im_addr", 64'(im_addr), 64'(IM_START));
    check("reset flags", 64'({load_im_done, eop, err}), 64'(0));
    check("reset strobes", 64'({mem_enable, mem_en_read, im_enable, im_en_write, dm_enable, dm_en_write}), 64'(0));
    check("reset addrs", 64'({rom_addr, mem_addr, dm_addr}), 64'(0));
    check("reset ir", 64'({ir_enable, total_ir, wr_data}), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_case(i);

    // Reset lands on the third COPY cycle of an 8-word IM copy: only two writes may appear.
    for (int j = 0; j < 256; j++) rom_mem[j] = 36'h0;
    rom_mem[0] = 36'hD_0040_0100;
    sb.delete();
    sb.push_back({1'b0, 14'h007F, mem_word(14'h0040)});
    sb.push_back({1'b0, 14'h0080, mem_word(14'h0041)});
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    c = 0;
    while (!mem_en_read && c < 50) begin
      @(negedge clock);
      c++;
    end
    check("abort first read seen", 64'(mem_en_read), 64'(1));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort busy", 64'(busy), 64'(0));
    check("abort im_addr", 64'(im_addr), 64'(IM_START));
    for (int k = 0; k < 3; k++) begin
      check("abort strobes", 64'({mem_enable, mem_en_read, im_enable, im_en_write, dm_enable, dm_en_write}), 64'(0));
      @(negedge clock);
    end
    reset = 1'b0;
    check("abort pending writes", 64'(sb.size()), 64'(0));
    check("abort flags", 64'({load_im_done, eop, err}), 64'(0));

    run_case(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
